// File: rtl/iiitb_sdgen.sv
// Serial sequence generator: captures a WIDTH-bit pattern on start and shifts it out
// MSB-first on dout, repeated rpt+1 times with an optional GAP-cycle idle spacing.
module iiitb_sdgen #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0,
  parameter int RPTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [RPTW-1:0]  rpt,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pat, pat_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic [RPTW-1:0]  repcnt, repcnt_nxt;
  logic [GW-1:0]    gapcnt, gapcnt_nxt;
  logic             dout_nxt, valid_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pat    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      repcnt <= '0;
      gapcnt <= '0;
      dout   <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pat    <= pat_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      repcnt <= repcnt_nxt;
      gapcnt <= gapcnt_nxt;
      dout   <= dout_nxt;
      valid  <= valid_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pat_nxt    = pat;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    repcnt_nxt = repcnt;
    gapcnt_nxt = gapcnt;
    dout_nxt   = dout;
    valid_nxt  = valid;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        dout_nxt  = 1'b0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start) begin
          pat_nxt    = pat_in;
          shreg_nxt  = pat_in;
          bitcnt_nxt = BIT_LAST;
          repcnt_nxt = rpt;
          dout_nxt   = pat_in[WIDTH-1];
          valid_nxt  = 1'b1;
          busy_nxt   = 1'b1;
          state_nxt  = S_SEND;
        end
      end

      S_SEND: begin
        if (bitcnt != '0) begin
          shreg_nxt  = shreg << 1;
          dout_nxt   = shreg[WIDTH-2];
          bitcnt_nxt = bitcnt - BW'(1);
        end else if (repcnt != '0) begin
          if (GAP == 0) begin
            // Repeats come from the captured copy so pat_in may change freely mid-burst.
            shreg_nxt  = pat;
            dout_nxt   = pat[WIDTH-1];
            bitcnt_nxt = BIT_LAST;
            repcnt_nxt = repcnt - RPTW'(1);
          end else begin
            dout_nxt   = 1'b0;
            valid_nxt  = 1'b0;
            gapcnt_nxt = GAP_LAST;
            state_nxt  = S_GAP;
          end
        end else begin
          dout_nxt  = 1'b0;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      S_GAP: begin
        dout_nxt  = 1'b0;
        valid_nxt = 1'b0;
        if (gapcnt == '0) begin
          shreg_nxt  = pat;
          dout_nxt   = pat[WIDTH-1];
          valid_nxt  = 1'b1;
          bitcnt_nxt = BIT_LAST;
          repcnt_nxt = repcnt - RPTW'(1);
          state_nxt  = S_SEND;
        end else begin
          gapcnt_nxt = gapcnt - GW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Cancel wins over every other transition and suppresses done.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      dout_nxt  = 1'b0;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_iiitb_sdgen.sv
// Bench for iiitb_sdgen: two instances (GAP=0 and GAP=2) share stimulus; a queue-based
// stream model plus directed vector tables check {dout,valid,busy,done} every cycle.
module tb_iiitb_sdgen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pat_in = '0;
  logic [3:0] rpt = '0;
  logic       dout0, valid0, busy0, done0;
  logic       dout1, valid1, busy1, done1;

  iiitb_sdgen #(.WIDTH(4), .GAP(0), .RPTW(4)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pat_in(pat_in), .rpt(rpt),
    .dout(dout0), .valid(valid0), .busy(busy0), .done(done0)
  );

  iiitb_sdgen #(.WIDTH(4), .GAP(2), .RPTW(4)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pat_in(pat_in), .rpt(rpt),
    .dout(dout1), .valid(valid1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dcnt0 = 0;
  int dcnt1 = 0;
  logic mchk = 1'b0;

  // Model state: current expected {dout,valid,busy,done} and the future output stream.
  logic [3:0] cur [2] = '{4'b0000, 4'b0000};
  logic [3:0] q [2][$];

  typedef struct {
    logic       start;
    logic [3:0] pat;
    logic [3:0] rpt;
    logic [3:0] e0;
    logic [3:0] e1;
  } vec_t;

  function automatic logic [3:0] obs(int d);
    return (d == 0) ? {dout0, valid0, busy0, done0} : {dout1, valid1, busy1, done1};
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_seq(int d, logic [3:0] p, logic [3:0] r);
    int gap;
    gap = (d == 0) ? 0 : 2;
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = 3; i >= 0; i--) q[d].push_back({p[i], 3'b110});
      if (k < int'(r))
        for (int g = 0; g < gap; g++) q[d].push_back(4'b0010);
    end
    q[d].push_back(4'b0001);
  endtask

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        q[d].delete();
        cur[d] = 4'b0000;
      end else if (abort && cur[d][1]) begin
        q[d].delete();
        cur[d] = 4'b0000;
      end else if (start && !cur[d][1]) begin
        load_seq(d, pat_in, rpt);
        cur[d] = q[d].pop_front();
      end else if (q[d].size() > 0) begin
        cur[d] = q[d].pop_front();
      end else begin
        cur[d] = 4'b0000;
      end
    end
  end

  always @(negedge clk) begin
    if (done0) dcnt0++;
    if (done1) dcnt1++;
    if (mchk) begin
      check("model_gap0", obs(0), cur[0]);
      check("model_gap2", obs(1), cur[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_seq(string name, logic [3:0] p, logic [3:0] r, logic [3:0] exp [5]);
    start = 1'b1; pat_in = p; rpt = r;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      check($sformatf("%s_%0d_d0", name, i), obs(0), exp[i]);
      check($sformatf("%s_%0d_d1", name, i), obs(1), exp[i]);
    end
  endtask

  initial begin
    vec_t tbl [18];
    logic [3:0] one [5];
    logic [3:0] b2b [6];
    logic [11:0] stream;
    int vcnt, occ, d0, d1;

    tbl[0]  = '{1'b1, 4'b1011, 4'd0, 4'b1110, 4'b1110};
    tbl[1]  = '{1'b0, 4'b1011, 4'd0, 4'b0110, 4'b0110};
    tbl[2]  = '{1'b0, 4'b1011, 4'd0, 4'b1110, 4'b1110};
    tbl[3]  = '{1'b0, 4'b1011, 4'd0, 4'b1110, 4'b1110};
    tbl[4]  = '{1'b0, 4'b1011, 4'd0, 4'b0001, 4'b0001};
    tbl[5]  = '{1'b0, 4'b1011, 4'd0, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b1, 4'b1100, 4'd1, 4'b1110, 4'b1110};
    tbl[7]  = '{1'b1, 4'b0000, 4'd0, 4'b1110, 4'b1110};
    tbl[8]  = '{1'b1, 4'b0000, 4'd0, 4'b0110, 4'b0110};
    tbl[9]  = '{1'b0, 4'b0000, 4'd0, 4'b0110, 4'b0110};
    tbl[10] = '{1'b0, 4'b0000, 4'd0, 4'b1110, 4'b0010};
    tbl[11] = '{1'b0, 4'b0000, 4'd0, 4'b1110, 4'b0010};
    tbl[12] = '{1'b0, 4'b0000, 4'd0, 4'b0110, 4'b1110};
    tbl[13] = '{1'b0, 4'b0000, 4'd0, 4'b0110, 4'b1110};
    tbl[14] = '{1'b0, 4'b0000, 4'd0, 4'b0001, 4'b0110};
    tbl[15] = '{1'b0, 4'b0000, 4'd0, 4'b0000, 4'b0110};
    tbl[16] = '{1'b0, 4'b0000, 4'd0, 4'b0000, 4'b0001};
    tbl[17] = '{1'b0, 4'b0000, 4'd0, 4'b0000, 4'b0000};
    one = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0001};
    b2b = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0001, 4'b1110};

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("reset_d0", obs(0), 4'b0000);
    check("reset_d1", obs(1), 4'b0000);
    #9 reset = 1'b0;
    @(negedge clk);
    mchk = 1'b1;

    // Directed vectors: single send, gap repeat, start/pattern change while busy
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start; pat_in = tbl[i].pat; rpt = tbl[i].rpt;
      step();
      check($sformatf("vec%0d_d0", i), obs(0), tbl[i].e0);
      check($sformatf("vec%0d_d1", i), obs(1), tbl[i].e1);
    end
    start = 1'b0;
    check_int("done_count_d0", dcnt0, 2);
    check_int("done_count_d1", dcnt1, 2);

    // 1011 x3 back-to-back stream as seen by the detector
    start = 1'b1; pat_in = 4'b1011; rpt = 4'd2;
    stream = '0; vcnt = 0; occ = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      start = 1'b0;
      stream = {stream[10:0], dout0};
      if (valid0) vcnt++;
      if (i >= 3 && stream[3:0] == 4'b1011) occ++;
    end
    check_int("stream_1011x3", int'(stream), int'(12'b101110111011));
    check_int("stream_valid", vcnt, 12);
    check_int("stream_detect", occ, 3);
    repeat (12) step();

    // start held through done: the next transmission follows with no idle cycle
    start = 1'b1; pat_in = 4'b1011; rpt = 4'd0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("b2b_%0d_d0", i), obs(0), b2b[i]);
      check($sformatf("b2b_%0d_d1", i), obs(1), b2b[i]);
    end
    start = 1'b0;
    repeat (6) step();

    // Abort on the third bit of a rpt=3 burst
    start = 1'b1; pat_in = 4'b1011; rpt = 4'd3;
    step(); start = 1'b0;
    step();
    step();
    check("abort_bit3_d0", obs(0), 4'b1110);
    d0 = dcnt0; d1 = dcnt1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle_d0", obs(0), 4'b0000);
    check("abort_idle_d1", obs(1), 4'b0000);
    repeat (4) step();
    check_int("abort_nodone_d0", dcnt0, d0);
    check_int("abort_nodone_d1", dcnt1, d1);
    run_seq("after_abort", 4'b1011, 4'd0, one);
    repeat (2) step();

    // Asynchronous reset between edges mid-transmission
    start = 1'b1; pat_in = 4'b1011; rpt = 4'd1;
    step(); start = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_d0", obs(0), 4'b0000);
    check("async_rst_d1", obs(1), 4'b0000);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_wait_d0", obs(0), 4'b0000);
    run_seq("after_rst", 4'b1011, 4'd0, one);
    repeat (2) step();

    // Randomized traffic against the stream model
    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 19) == 0);
      pat_in = 4'($urandom);
      rpt    = 4'($urandom_range(0, 3));
      step();
    end
    start = 1'b0; abort = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
